uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver.
//
// Purpose:
//   Receives asynchronous serial frames: start bit, DATA_BITS data bits
//   (LSB first), an optional even-parity bit, and one stop bit. The line is
//   sampled once per bit period, in the middle of the bit. Timing is set by
//   an external baud_tick strobe running at OVERSAMPLE times the baud rate.
//
// Parameters:
//   OVERSAMPLE  baud_tick pulses per bit period (even, >= 4)
//   DATA_BITS   data bits per frame
//
// Ports:
//   clk         system clock; all state changes on its rising edge
//   rst         asynchronous active-high reset
//   baud_tick   one-clk strobe at OVERSAMPLE x baud
//   rx          serial input, idle high, asynchronous to clk
//   rx_data     last correctly received word
//   rx_done     one-clk pulse when rx_data has been updated
//   rx_busy     high while a frame is being received
//   frame_err   one-clk pulse when the stop bit is sampled low
//   parity_err  one-clk pulse on a parity mismatch (tied low without parity)
//
// Build option:
//   UART_RX_PARITY_EN  when defined, adds a PARITY state that checks even
//                      parity over the data bits.

module uart_rx #(
   parameter int OVERSAMPLE = 8,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 rx_busy,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   // Two-flop synchronizer; both flops preset to the idle (high) level so
   // reset does not fake a start bit.
   logic meta_q, meta_d;
   logic rx_s_q, rx_s_d;

   always_comb begin
      meta_d = rx;
      rx_s_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         rx_s_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         rx_s_q <= rx_s_d;
      end
   end

   state_t               state_q, state_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 done_q, done_d;
   logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                 perr_q, perr_d;
   logic                 par_bad_q, par_bad_d;   // parity mismatch seen this frame
`endif

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d    = 1'b0;
      par_bad_d = par_bad_q;
`endif
      if (baud_tick) begin
         case (state_q)
            IDLE: begin
               if (!rx_s_q) begin
                  state_d = START;
                  tick_d  = '0;
               end
            end
            START: begin
               // Re-check the line half a bit in to reject glitches.
               if (tick_q == TICK_HALF) begin
                  if (rx_s_q) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            DATA: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  shift_d = shift_q >> 1;
                  shift_d[DATA_BITS-1] = rx_s_q;
                  if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick_q == TICK_LAST) begin
                  tick_d    = '0;
                  // Even parity: data bits XOR parity bit must be 0.
                  par_bad_d = rx_s_q ^ (^shift_q);
                  state_d   = STOP;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
`endif
            STOP: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  state_d = IDLE;
                  if (!rx_s_q) begin
                     ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (par_bad_q) begin
                     perr_d = 1'b1;
`endif
                  end else begin
                     done_d = 1'b1;
                     data_d = shift_q;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q    <= perr_d;
         par_bad_q <= par_bad_d;
`endif
      end
   end

   assign rx_data   = data_q;
   assign rx_done   = done_q;
   assign frame_err = ferr_q;
   assign rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
